// File: rtl/l1_cache_pkg.sv
// Shared types and address-split helpers for the set-associative L1 instruction cache.
package l1_cache_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MISS = 1'b1
    } state_t;

    // Upper bound on line size so one helper can serve every WORDS setting.
    localparam int MAX_WORDS  = 64;
    localparam int LINE_MAX_W = 32 * MAX_WORDS;
    localparam int OFF_MAX_W  = 6;

    function automatic int off_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int sets, input int words);
        return addr_w - $clog2(sets) - $clog2(words);
    endfunction

    function automatic logic [31:0] line_word(input logic [LINE_MAX_W-1:0] line,
                                              input logic [OFF_MAX_W-1:0]  off);
        return line[{off, 5'd0} +: 32];
    endfunction

endpackage

// File: rtl/l1_cache_way.sv
// One cache way: valid bits, tag and line storage with a combinational lookup
// and a single-line fill port.
module l1_cache_way #(
    parameter int SETS  = 8,
    parameter int WORDS = 4,
    parameter int IDX_W = 3,
    parameter int TAG_W = 25,
    parameter int OFF_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [IDX_W-1:0]      idx,
    input  logic [TAG_W-1:0]      tag,
    input  logic [OFF_W-1:0]      off,
    output logic                  hit,
    output logic                  valid,
    output logic [31:0]           word,
    input  logic                  fill,
    input  logic [32*WORDS-1:0]   fill_line
);
    import l1_cache_pkg::*;

    logic [SETS-1:0]     valid_reg;
    logic [TAG_W-1:0]    tag_mem  [SETS];
    logic [32*WORDS-1:0] data_mem [SETS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
        end else if (flush) begin
            valid_reg <= '0;
        end else if (fill) begin
            valid_reg[idx] <= 1'b1;
        end
    end

    // Tag and data storage carry no reset so they can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= fill_line;
        end
    end

    assign valid = valid_reg[idx];
    assign hit   = valid_reg[idx] && (tag_mem[idx] == tag);
    assign word  = line_word(LINE_MAX_W'(data_mem[idx]), OFF_MAX_W'(off));

endmodule

// File: rtl/l1_icache_assoc.sv
// Read-only L1 instruction cache, 1 or 2 ways with per-set LRU, L2 line fill,
// whole-cache flush and saturating hit/miss counters.
module l1_icache_assoc #(
    parameter int ADDR_W = 30,
    parameter int SETS   = 8,
    parameter int WAYS   = 2,
    parameter int WORDS  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  proc_reset_n,
    input  logic                  proc_read,
    input  logic [ADDR_W-1:0]     proc_addr,
    input  logic                  proc_flush,
    output logic [31:0]           proc_rdata,
    output logic                  proc_stall,
    output logic                  L2_read,
    output logic [ADDR_W-1:0]     L2_addr,
    input  logic [32*WORDS-1:0]   L2_rdata,
    input  logic                  L2_ready,
    output logic [CNT_W-1:0]      hit_cnt,
    output logic [CNT_W-1:0]      miss_cnt
);
    import l1_cache_pkg::*;

    localparam int OFF_W = off_w(WORDS);
    localparam int IDX_W = idx_w(SETS);
    localparam int TAG_W = tag_w(ADDR_W, SETS, WORDS);

    state_t              state_reg, state_next;
    logic [SETS-1:0]     lru_reg;
    logic                flush_pend_reg;
    logic                l2_read_reg;
    logic [ADDR_W-1:0]   l2_addr_reg;
    logic [CNT_W-1:0]    hit_cnt_reg, miss_cnt_reg;

    logic [OFF_W-1:0]    off;
    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    tag;
    logic [WAYS-1:0]     way_hit, way_valid, way_fill;
    logic [31:0]         way_word [WAYS];
    logic [31:0]         hit_word;
    logic                hit, hit_way, victim;
    logic                do_flush, miss_start, fill, serviced;

    assign off = proc_addr[OFF_W-1:0];
    assign idx = proc_addr[OFF_W +: IDX_W];
    assign tag = proc_addr[ADDR_W-1 -: TAG_W];

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            assign way_fill[gi] = fill && (victim == 1'(gi));
            l1_cache_way #(
                .SETS(SETS), .WORDS(WORDS), .IDX_W(IDX_W), .TAG_W(TAG_W), .OFF_W(OFF_W)
            ) u_way (
                .clk(clk), .rst_n(proc_reset_n), .flush(do_flush),
                .idx(idx), .tag(tag), .off(off),
                .hit(way_hit[gi]), .valid(way_valid[gi]), .word(way_word[gi]),
                .fill(way_fill[gi]), .fill_line(L2_rdata)
            );
        end
    endgenerate

    always_comb begin
        hit_word = '0;
        hit_way  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_hit[w]) begin
                hit_word = way_word[w];
                hit_way  = 1'(w);
            end
        end
    end
    assign hit = |way_hit;

    // Fill the first empty way (way 0 first), otherwise the least-recently-used one.
    always_comb begin
        victim = 1'b0;
        if (WAYS == 2 && way_valid[0]) begin
            victim = way_valid[WAYS-1] ? lru_reg[idx] : 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        do_flush   = 1'b0;
        miss_start = 1'b0;
        fill       = 1'b0;
        proc_stall = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (flush_pend_reg || proc_flush) begin
                    do_flush   = 1'b1;
                    proc_stall = proc_read;
                end else if (proc_read && !hit) begin
                    miss_start = 1'b1;
                    proc_stall = 1'b1;
                    state_next = ST_MISS;
                end
            end
            ST_MISS: begin
                proc_stall = proc_read;
                if (L2_ready) begin
                    fill       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign serviced   = proc_read && !proc_stall;
    assign proc_rdata = serviced ? hit_word : 32'd0;

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state_reg      <= ST_IDLE;
            lru_reg        <= '0;
            flush_pend_reg <= 1'b0;
            l2_read_reg    <= 1'b0;
            l2_addr_reg    <= '0;
            hit_cnt_reg    <= '0;
            miss_cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (do_flush) begin
                flush_pend_reg <= 1'b0;
            end else if (state_reg == ST_MISS && proc_flush) begin
                flush_pend_reg <= 1'b1;
            end
            if (miss_start) begin
                l2_read_reg <= 1'b1;
                l2_addr_reg <= {proc_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            end else if (fill) begin
                l2_read_reg <= 1'b0;
            end
            if (do_flush) begin
                lru_reg <= '0;
            end else if (fill) begin
                lru_reg[idx] <= ~victim;
            end else if (serviced) begin
                lru_reg[idx] <= ~hit_way;
            end
            if (serviced && hit_cnt_reg != '1) begin
                hit_cnt_reg <= hit_cnt_reg + CNT_W'(1);
            end
            if (miss_start && miss_cnt_reg != '1) begin
                miss_cnt_reg <= miss_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign L2_read  = l2_read_reg;
    assign L2_addr  = l2_addr_reg;
    assign hit_cnt  = hit_cnt_reg;
    assign miss_cnt = miss_cnt_reg;

endmodule

// File: tb/tb_l1_icache_assoc.sv
// Directed bench for l1_icache_assoc: stimulus queues expected read data, a
// monitor checks every serviced read, and a 3-cycle L2 model answers fills.
module tb_l1_icache_assoc;

    logic         clk = 1'b0;
    logic         proc_reset_n;
    logic         proc_read;
    logic [29:0]  proc_addr;
    logic         proc_flush;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         L2_read;
    logic [29:0]  L2_addr;
    logic [127:0] L2_rdata;
    logic         L2_ready;
    logic [15:0]  hit_cnt;
    logic [15:0]  miss_cnt;

    logic model_ready  = 1'b0;
    logic manual_ready = 1'b0;
    logic l2_auto      = 1'b1;
    int   l2_cnt       = 0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [29:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    assign L2_ready = model_ready | manual_ready;

    always #5 clk = ~clk;

    l1_icache_assoc dut (
        .clk(clk), .proc_reset_n(proc_reset_n), .proc_read(proc_read),
        .proc_addr(proc_addr), .proc_flush(proc_flush), .proc_rdata(proc_rdata),
        .proc_stall(proc_stall), .L2_read(L2_read), .L2_addr(L2_addr),
        .L2_rdata(L2_rdata), .L2_ready(L2_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    // Word k of the line at base B is 0xC0DE0000 + B*16 + k.
    function automatic logic [127:0] make_line(input logic [29:0] base);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) begin
            l[32*k +: 32] = 32'hC0DE_0000 + 32'(base) * 32'd16 + 32'(k);
        end
        return l;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic expect_read(input logic [29:0] a, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Entered at negedge+1 while a read is outstanding.
    task automatic wait_done(input string name);
        int n = 0;
        while (proc_stall && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (proc_stall) begin
            errors++;
            $display("FAIL %s_timeout: stall still 1 after %0d cycles, required 0", name, n);
        end
        @(negedge clk);
        proc_read = 1'b0;
    endtask

    // Entered at a negedge; returns at a negedge with proc_read dropped.
    task automatic do_read(input logic [29:0] a, input logic [31:0] d, input bit exp_hit);
        expect_read(a, d);
        proc_read = 1'b1;
        proc_addr = a;
        #1;
        check($sformatf("stall_%h", a), 32'(proc_stall), exp_hit ? 32'd0 : 32'd1);
        wait_done($sformatf("read_%h", a));
    endtask

    task automatic flush_pulse();
        proc_flush = 1'b1;
        @(negedge clk);
        proc_flush = 1'b0;
    endtask

    // L2 model: answers a fill in the third cycle L2_read is seen high.
    initial begin
        L2_rdata = '0;
        forever begin
            @(negedge clk);
            model_ready = 1'b0;
            if (l2_auto && L2_read && proc_reset_n) begin
                l2_cnt++;
                if (l2_cnt == 3) begin
                    model_ready = 1'b1;
                    L2_rdata    = make_line(L2_addr);
                    l2_cnt      = 0;
                end
            end else begin
                l2_cnt = 0;
            end
        end
    end

    // Monitor: every serviced read is compared against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (proc_reset_n && proc_read && !proc_stall) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read: addr %h data %h, required no read", proc_addr, proc_rdata);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("rdata_%h", e.addr), proc_rdata, e.data);
                    $display("read addr %h data %h hit_cnt %0d miss_cnt %0d", proc_addr, proc_rdata, hit_cnt, miss_cnt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        proc_reset_n = 1'b0;
        proc_read    = 1'b0;
        proc_addr    = '0;
        proc_flush   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_l2_read", 32'(L2_read), 32'd0);
        check("rst_l2_addr", 32'(L2_addr), 32'd0);
        check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
        check("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        check("rst_stall", 32'(proc_stall), 32'd0);
        check("rst_rdata", proc_rdata, 32'd0);
        @(negedge clk);
        proc_reset_n = 1'b1;

        // Cold miss, cycle by cycle.
        @(negedge clk);
        expect_read(30'h40, 32'hC0DE_0400);
        proc_read = 1'b1;
        proc_addr = 30'h40;
        #1;
        check("cold_c0_stall", 32'(proc_stall), 32'd1);
        check("cold_c0_l2_read", 32'(L2_read), 32'd0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk); #1;
            check($sformatf("cold_c%0d_l2_read", c), 32'(L2_read), 32'd1);
            check($sformatf("cold_c%0d_l2_addr", c), 32'(L2_addr), 32'h40);
            check($sformatf("cold_c%0d_stall", c), 32'(proc_stall), 32'd1);
        end
        @(negedge clk); #1;
        check("cold_c4_stall", 32'(proc_stall), 32'd0);
        check("cold_c4_l2_read", 32'(L2_read), 32'd0);
        check("cold_c4_miss_cnt", 32'(miss_cnt), 32'd1);
        @(negedge clk);
        proc_read = 1'b0;
        #1;
        check("cold_hit_cnt", 32'(hit_cnt), 32'd1);
        @(negedge clk);

        // Word select within the cached line.
        do_read(30'h43, 32'hC0DE_0403, 1'b1);
        check("wsel_hit_cnt", 32'(hit_cnt), 32'd2);
        check("wsel_miss_cnt", 32'(miss_cnt), 32'd1);

        // LRU: 0x40 way0, 0x80 way1, touch 0x40, 0xC0 evicts 0x80.
        do_read(30'h80, 32'hC0DE_0800, 1'b0);
        do_read(30'h40, 32'hC0DE_0400, 1'b1);
        do_read(30'hC0, 32'hC0DE_0C00, 1'b0);
        do_read(30'h40, 32'hC0DE_0400, 1'b1);
        do_read(30'h80, 32'hC0DE_0800, 1'b0);
        check("lru_miss_cnt", 32'(miss_cnt), 32'd4);
        check("lru_hit_cnt", 32'(hit_cnt), 32'd7);

        // Flush in IDLE wins over a read of a cached line.
        expect_read(30'h40, 32'hC0DE_0400);
        proc_flush = 1'b1;
        proc_read  = 1'b1;
        proc_addr  = 30'h40;
        #1;
        check("fidle_stall", 32'(proc_stall), 32'd1);
        @(negedge clk);
        proc_flush = 1'b0;
        #1;
        check("fidle_miss_stall", 32'(proc_stall), 32'd1);
        @(negedge clk); #1;
        check("fidle_l2_read", 32'(L2_read), 32'd1);
        check("fidle_l2_addr", 32'(L2_addr), 32'h40);
        wait_done("fidle");
        check("fidle_miss_cnt", 32'(miss_cnt), 32'd5);

        // Flush raised during a fill executes right after it.
        flush_pulse();
        expect_read(30'h40, 32'hC0DE_0400);
        proc_read = 1'b1;
        proc_addr = 30'h40;
        #1;
        check("fmiss_c0_stall", 32'(proc_stall), 32'd1);
        @(negedge clk);
        proc_flush = 1'b1;
        @(negedge clk);
        proc_flush = 1'b0;
        @(negedge clk); #1;
        check("fmiss_c3_stall", 32'(proc_stall), 32'd1);
        @(negedge clk); #1;
        check("fmiss_c4_flush_stall", 32'(proc_stall), 32'd1);
        check("fmiss_c4_l2_read", 32'(L2_read), 32'd0);
        @(negedge clk); #1;
        check("fmiss_c5_stall", 32'(proc_stall), 32'd1);
        @(negedge clk); #1;
        check("fmiss_c6_l2_read", 32'(L2_read), 32'd1);
        check("fmiss_c6_l2_addr", 32'(L2_addr), 32'h40);
        wait_done("fmiss");
        check("fmiss_miss_cnt", 32'(miss_cnt), 32'd7);

        // Reset in the middle of a fill.
        flush_pulse();
        l2_auto   = 1'b0;
        proc_read = 1'b1;
        proc_addr = 30'h40;
        @(negedge clk);
        @(negedge clk); #1;
        check("rmid_l2_read_before", 32'(L2_read), 32'd1);
        proc_reset_n = 1'b0;
        #1;
        check("rmid_l2_read", 32'(L2_read), 32'd0);
        check("rmid_hit_cnt", 32'(hit_cnt), 32'd0);
        check("rmid_miss_cnt", 32'(miss_cnt), 32'd0);
        proc_read = 1'b0;
        @(negedge clk);
        proc_reset_n = 1'b1;
        @(negedge clk);
        manual_ready = 1'b1;
        @(negedge clk);
        manual_ready = 1'b0;
        #1;
        check("rmid_late_l2_read", 32'(L2_read), 32'd0);
        check("rmid_late_miss_cnt", 32'(miss_cnt), 32'd0);
        l2_auto = 1'b1;
        @(negedge clk);
        do_read(30'h40, 32'hC0DE_0400, 1'b0);
        check("rmid_after_miss_cnt", 32'(miss_cnt), 32'd1);
        check("rmid_after_hit_cnt", 32'(hit_cnt), 32'd1);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
